store_drain_arbiter: RTL and testbench

- Owns the single data-memory port and shares it between two requesters: load-unit reads and the drain of committed stores from the store buffer's committed section.
- Loads have priority by default. Stores take over when the committed backlog crosses a high watermark, or when a store has been starved too long.
- All memory-port outputs are registered. The memory is a synchronous RAM with 1-cycle read latency.

---
 rtl/store_drain_arbiter.sv | 163 ++++++++++++++++
 tb/tb_store_drain_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_arbiter.sv
// store_drain_arbiter: owns the single data-memory port and shares it between
// load-unit reads and the drain of committed stores.
//   - LOAD_PRI: loads win unless a valid store has waited STARVE_LIMIT cycles.
//   - DRAIN   : stores win while the committed backlog is being worked down.
// Memory-port outputs are registered; RAM read latency is one cycle.
// Optional build macro ARB_STATS_EN adds the stat_ld_stall / stat_drain_cycles
// saturating counters.
//
// Handshakes: a load transfers in a cycle where ld_req_valid && ld_req_ready;
// ld_req_ready is combinational and is only ever high while ld_req_valid is
// high and flush is low. A store is consumed in a cycle where st_valid &&
// st_pop; st_pop is combinational and only high while st_valid is high.
module store_drain_arbiter #(
  parameter int DRAIN_HI     = 12,
  parameter int DRAIN_LO     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ld_req_valid,
  input  logic [15:0] ld_req_addr,
  output logic        ld_req_ready,
  output logic        ld_resp_valid,
  output logic [15:0] ld_resp_data,
  input  logic        st_valid,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  input  logic [4:0]  st_count,
  output logic        st_pop,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        drain_busy,
`ifdef ARB_STATS_EN
  output logic [15:0] stat_ld_stall,
  output logic [15:0] stat_drain_cycles,
`endif
  output logic        state_dbg
);

  // Reject illegal watermark / starvation settings at elaboration.
  if (!(DRAIN_LO < DRAIN_HI && DRAIN_HI <= 16 && STARVE_LIMIT >= 1)) begin : g_param_check
    $error("store_drain_arbiter: need DRAIN_LO < DRAIN_HI <= 16 and STARVE_LIMIT >= 1");
  end

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [4:0]    HI_MARK   = 5'(DRAIN_HI);
  localparam logic [4:0]    LO_MARK   = 5'(DRAIN_LO);
  localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

  typedef enum logic {
    LOAD_PRI = 1'b0,
    DRAIN    = 1'b1
  } arb_state_t;

  arb_state_t    state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          ld_elig;
  logic          grant_ld, grant_st;
  logic          rd_pend;       // read is on the memory port this cycle
  logic          resp_q;        // read data is on mem_rdata this cycle
  logic [15:0]   resp_data_q;   // last delivered load data

  assign ld_elig      = ld_req_valid & ~flush;
  assign ld_req_ready = grant_ld;
  assign st_pop       = grant_st;
  assign drain_busy   = (state == DRAIN);
  assign state_dbg    = state;

  // Response is presented straight from the RAM output, then held.
  assign ld_resp_valid = resp_q;
  assign ld_resp_data  = resp_q ? mem_rdata : resp_data_q;

  // Grant selection, starvation counting and watermark transitions.
  always_comb begin
    grant_ld   = 1'b0;
    grant_st   = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      LOAD_PRI: begin
        if (ld_elig && (starve_cnt < STARVE_MX)) grant_ld = 1'b1;
        else if (st_valid)                       grant_st = 1'b1;
        if (!st_valid || grant_st)        starve_nxt = '0;
        else if (starve_cnt != STARVE_MX) starve_nxt = starve_cnt + SW'(1);
        if (st_count >= HI_MARK) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (st_valid)     grant_st = 1'b1;
        else if (ld_elig) grant_ld = 1'b1;
        starve_nxt = '0;
        if (st_count <= LO_MARK) state_nxt = LOAD_PRI;
      end
      default: begin
        state_nxt  = LOAD_PRI;
        starve_nxt = '0;
      end
    endcase
  end

  // FSM state and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Registered memory port; address/data hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= grant_ld | grant_st;
      if (grant_st) begin
        mem_we    <= 1'b1;
        mem_addr  <= st_addr;
        mem_wdata <= st_data;
      end else if (grant_ld) begin
        mem_we   <= 1'b0;
        mem_addr <= ld_req_addr;
      end
    end
  end

  // Read tracking; a flush while the read is on the port kills its response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      resp_q      <= 1'b0;
      resp_data_q <= '0;
    end else begin
      rd_pend <= grant_ld;
      resp_q  <= rd_pend & ~flush;
      if (resp_q) resp_data_q <= mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ld_stall     <= '0;
      stat_drain_cycles <= '0;
    end else begin
      if (ld_elig && !grant_ld && stat_ld_stall != 16'hFFFF)
        stat_ld_stall <= stat_ld_stall + 16'd1;
      if (state == DRAIN && stat_drain_cycles != 16'hFFFF)
        stat_drain_cycles <= stat_drain_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_store_drain_arbiter.sv
// tb_store_drain_arbiter: directed vectors with hand-computed expectations for
// store_drain_arbiter (default parameters). A small synchronous RAM model sits
// on the memory port. Define ARB_STATS_EN to also cover the stat counters.
module tb_store_drain_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        ld_req_valid = 1'b0;
  logic [15:0] ld_req_addr = '0;
  logic        ld_req_ready;
  logic        ld_resp_valid;
  logic [15:0] ld_resp_data;
  logic        st_valid = 1'b0;
  logic [15:0] st_addr = '0;
  logic [15:0] st_data = '0;
  logic [4:0]  st_count = '0;
  logic        st_pop;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        drain_busy;
  logic        state_dbg;
`ifdef ARB_STATS_EN
  logic [15:0] stat_ld_stall, stat_drain_cycles;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] ram [0:255];

  store_drain_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_count(st_count),
    .st_pop(st_pop),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .drain_busy(drain_busy),
`ifdef ARB_STATS_EN
    .stat_ld_stall(stat_ld_stall), .stat_drain_cycles(stat_drain_cycles),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush = 1'b0;
    ld_req_valid = 1'b0;
    st_valid = 1'b0;
    st_count = 5'd0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 3);
    ram[8'h40] = 16'hBEEF;
    ram[8'h60] = 16'hCAFE;

    // Reset state.
    #2;
    check("rst_mem_en", mem_en, 0);
    check("rst_drain_busy", drain_busy, 0);
    check("rst_resp_valid", ld_resp_valid, 0);
    next_cycle();
    reset = 1'b0;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_state", state_dbg, 0);

    // Load only.
    next_cycle();
    ld_req_valid = 1'b1; ld_req_addr = 16'h0040;
    #1;
    check("ld_ready_c0", ld_req_ready, 1);
    check("ld_no_pop_c0", st_pop, 0);
    next_cycle();
    ld_req_valid = 1'b0;
    #1;
    check("ld_mem_en_c1", mem_en, 1);
    check("ld_mem_we_c1", mem_we, 0);
    check("ld_mem_addr_c1", mem_addr, 16'h0040);
    check("ld_resp_c1", ld_resp_valid, 0);
    next_cycle();
    check("ld_resp_c2", ld_resp_valid, 1);
    check("ld_data_c2", ld_resp_data, 16'hBEEF);
    next_cycle();
    check("ld_resp_pulse_c3", ld_resp_valid, 0);
    check("ld_data_hold_c3", ld_resp_data, 16'hBEEF);
    check("ld_mem_en_c3", mem_en, 0);

    // Starvation: 8 load grants, then a forced store grant.
    next_cycle();
    ld_req_valid = 1'b1; st_valid = 1'b1; st_count = 5'd2;
    st_addr = 16'h0020; st_data = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      ld_req_addr = 16'(16'h0080 + i);
      #1;
      check("starve_ld_grant", ld_req_ready, 1);
      check("starve_no_pop", st_pop, 0);
      next_cycle();
    end
    #1;
    check("starve_pop_c8", st_pop, 1);
    check("starve_ld_block_c8", ld_req_ready, 0);
    next_cycle();
    #1;
    check("starve_mem_we_c9", mem_we, 1);
    check("starve_mem_addr_c9", mem_addr, 16'h0020);
    check("starve_mem_wdata_c9", mem_wdata, 16'h1234);
    check("starve_ld_resume_c9", ld_req_ready, 1);
    next_cycle();
    drive_idle();
    repeat (3) next_cycle();

    // Watermark: enter DRAIN at 12, leave at 4.
    ld_req_valid = 1'b1; ld_req_addr = 16'h00A0;
    st_valid = 1'b1; st_count = 5'd12; st_addr = 16'h0030; st_data = 16'h5555;
    #1;
    check("wm_ld_grant_c0", ld_req_ready, 1);
    check("wm_busy_c0", drain_busy, 0);
    next_cycle();
    #1;
    check("wm_busy_c1", drain_busy, 1);
    check("wm_pop_c1", st_pop, 1);
    check("wm_ld_block_c1", ld_req_ready, 0);
    next_cycle();
    st_count = 5'd8;
    #1;
    check("wm_pop_c2", st_pop, 1);
    check("wm_mem_we_c2", mem_we, 1);
    check("wm_mem_addr_c2", mem_addr, 16'h0030);
    next_cycle();
    st_count = 5'd4;
    #1;
    check("wm_busy_c3", drain_busy, 1);
    check("wm_pop_c3", st_pop, 1);
    next_cycle();
    st_count = 5'd3;
    #1;
    check("wm_exit_c4", drain_busy, 0);
    check("wm_ld_again_c4", ld_req_ready, 1);
    check("wm_no_pop_c4", st_pop, 0);
    next_cycle();
    drive_idle();
    repeat (3) next_cycle();

    // DRAIN entered with no store at the head: loads still served.
    ld_req_valid = 1'b1; ld_req_addr = 16'h00B0; st_count = 5'd12;
    #1;
    check("dn_ld_c0", ld_req_ready, 1);
    next_cycle();
    #1;
    check("dn_busy_c1", drain_busy, 1);
    check("dn_ld_c1", ld_req_ready, 1);
    next_cycle();
    st_valid = 1'b1; st_count = 5'd2; st_addr = 16'h0034;
    #1;
    check("dn_pop_c2", st_pop, 1);
    check("dn_ld_block_c2", ld_req_ready, 0);
    next_cycle();
    drive_idle();
    #1;
    check("dn_exit_c3", drain_busy, 0);
    repeat (3) next_cycle();

    // Flush kill: load in cycle 0, flush in cycle 1 while a store is granted.
    ld_req_valid = 1'b1; ld_req_addr = 16'h0050;
    #1;
    check("fl_ld_c0", ld_req_ready, 1);
    next_cycle();
    flush = 1'b1; st_valid = 1'b1; st_count = 5'd1;
    st_addr = 16'h0010; st_data = 16'hAAAA;
    #1;
    check("fl_ready_c1", ld_req_ready, 0);
    check("fl_pop_c1", st_pop, 1);
    check("fl_mem_addr_c1", mem_addr, 16'h0050);
    next_cycle();
    drive_idle();
    #1;
    check("fl_no_resp_c2", ld_resp_valid, 0);
    check("fl_mem_we_c2", mem_we, 1);
    check("fl_mem_addr_c2", mem_addr, 16'h0010);
    check("fl_mem_wdata_c2", mem_wdata, 16'hAAAA);
    repeat (2) next_cycle();

    // Flush in the response cycle does not retract it.
    ld_req_valid = 1'b1; ld_req_addr = 16'h0060;
    #1;
    check("fl2_ld_c0", ld_req_ready, 1);
    next_cycle();
    ld_req_valid = 1'b0;
    next_cycle();
    flush = 1'b1;
    #1;
    check("fl2_resp_c2", ld_resp_valid, 1);
    check("fl2_data_c2", ld_resp_data, 16'hCAFE);
    next_cycle();
    drive_idle();
    repeat (2) next_cycle();

    // Async reset mid-cycle during a store write, from DRAIN.
    st_valid = 1'b1; st_count = 5'd12; st_addr = 16'h0044; st_data = 16'h7777;
    #1;
    check("ar_pop_c0", st_pop, 1);
    next_cycle();
    #1;
    check("ar_mem_en_c1", mem_en, 1);
    check("ar_mem_we_c1", mem_we, 1);
    check("ar_busy_c1", drain_busy, 1);
    #1;
    reset = 1'b1;
    drive_idle();
    #1;
    check("ar_mem_en_async", mem_en, 0);
    check("ar_mem_we_async", mem_we, 0);
    check("ar_mem_addr_async", mem_addr, 0);
    check("ar_mem_wdata_async", mem_wdata, 0);
    check("ar_busy_async", drain_busy, 0);
    check("ar_resp_data_async", ld_resp_data, 0);
    next_cycle();
    reset = 1'b0;
    #1;
    check("ar_state_after", state_dbg, 0);
    check("ar_resp_valid_after", ld_resp_valid, 0);
    check("ar_pop_after", st_pop, 0);
    next_cycle();
    ld_req_valid = 1'b1; ld_req_addr = 16'h00C0; st_valid = 1'b1; st_count = 5'd1;
    #1;
    check("ar_ld_priority", ld_req_ready, 1);

    // Five DRAIN cycles with a blocked load.
    next_cycle();
    ld_req_valid = 1'b0; st_count = 5'd12;
    #1;
    check("st_pop_enter", st_pop, 1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      ld_req_valid = 1'b1;
      st_count = (i == 4) ? 5'd4 : 5'd12;
      #1;
      check("st_drain_busy", drain_busy, 1);
      check("st_ld_blocked", ld_req_ready, 0);
    end
    next_cycle();
    drive_idle();
    #1;
    check("st_exit", drain_busy, 0);
`ifdef ARB_STATS_EN
    check("stat_drain_cycles", stat_drain_cycles, 5);
    check("stat_ld_stall", stat_ld_stall, 5);
`endif

    repeat (2) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
